// File: rtl/bdd_tree_loader.sv
// Byte-stream loader for decision-tree node memories: parses a framed tree image,
// emits coefficient/child memory writes and raises tree_valid after a clean checksum.
module bdd_tree_loader #(
  parameter int ADDR_WIDTH  = 6,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  abort,
  output logic                  coef_we,
  output logic [ADDR_WIDTH-1:0] coef_addr,
  output logic [47:0]           coef_wdata,
  output logic                  child_we,
  output logic [ADDR_WIDTH-1:0] child_addr,
  output logic [17:0]           child_wdata,
  output logic                  load_busy,
  output logic                  tree_valid,
  output logic                  load_err,
  output logic [1:0]            err_code
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, COUNT, NODE, CHECK} state_t;

  state_t                  state, state_nx;
  logic [ADDR_WIDTH-1:0]   node_idx;
  logic [7:0]              n_reg;
  logic [3:0]              byte_idx;
  logic [7:0]              xor_acc;
  logic [7:0]              nbuf [0:7];
  logic [TW-1:0]           tmo_cnt;

  logic acc, hdr, cnt_bad, last_node, node_end, tmo_hit;

  always_comb begin
    acc       = s_valid && s_ready && !abort;
    hdr       = acc && (state == IDLE) && (s_data == 8'hA5);
    cnt_bad   = (s_data == 8'h00) || (int'(s_data) > DEPTH);
    last_node = (int'(node_idx) + 1) == int'(n_reg);
    node_end  = acc && (state == NODE) && (byte_idx == 4'd8);
    tmo_hit   = (state != IDLE) && !acc && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
  end

  assign load_busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (abort)        state_nx = IDLE;
    else if (tmo_hit) state_nx = IDLE;
    else begin
      case (state)
        IDLE:  if (hdr) state_nx = COUNT;
        COUNT: if (acc) state_nx = cnt_bad ? IDLE : NODE;
        NODE:  if (node_end && last_node) state_nx = CHECK;
        CHECK: if (acc) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready     <= 1'b0;
      coef_we     <= 1'b0;
      coef_addr   <= '0;
      coef_wdata  <= '0;
      child_we    <= 1'b0;
      child_addr  <= '0;
      child_wdata <= '0;
      tree_valid  <= 1'b0;
      load_err    <= 1'b0;
      err_code    <= '0;
      node_idx    <= '0;
      n_reg       <= '0;
      byte_idx    <= '0;
      xor_acc     <= '0;
      tmo_cnt     <= '0;
      for (int unsigned i = 0; i < 8; i++) nbuf[i] <= '0;
    end else begin
      s_ready  <= 1'b1;
      coef_we  <= 1'b0;
      child_we <= 1'b0;
      if (abort) begin
        // Strobes registered last cycle have already fired; only flags are dropped here.
        tree_valid <= 1'b0;
        load_err   <= 1'b0;
        err_code   <= '0;
        tmo_cnt    <= '0;
      end else begin
        if (state == IDLE || acc) tmo_cnt <= '0;
        else if (!tmo_hit)        tmo_cnt <= tmo_cnt + 1'b1;
        if (tmo_hit) begin
          load_err <= 1'b1;
          err_code <= 2'd3;
        end
        case (state)
          IDLE: if (hdr) begin
            tree_valid <= 1'b0;
            load_err   <= 1'b0;
            err_code   <= '0;
            node_idx   <= '0;
            byte_idx   <= '0;
            xor_acc    <= '0;
          end
          COUNT: if (acc) begin
            if (cnt_bad) begin
              load_err <= 1'b1;
              err_code <= 2'd1;
            end else begin
              n_reg   <= s_data;
              xor_acc <= s_data;
            end
          end
          NODE: if (acc) begin
            xor_acc <= xor_acc ^ s_data;
            if (byte_idx < 4'd8) begin
              nbuf[byte_idx[2:0]] <= s_data;
              byte_idx            <= byte_idx + 1'b1;
            end
            if (byte_idx == 4'd5) begin
              coef_we    <= 1'b1;
              coef_addr  <= node_idx;
              coef_wdata <= {nbuf[0], nbuf[1], nbuf[2], nbuf[3], nbuf[4], s_data};
            end
            if (byte_idx == 4'd8) begin
              child_we    <= 1'b1;
              child_addr  <= node_idx;
              child_wdata <= {nbuf[6][1:0], nbuf[7], s_data};
              byte_idx    <= '0;
              node_idx    <= node_idx + 1'b1;
            end
          end
          CHECK: if (acc) begin
            if (s_data == xor_acc) tree_valid <= 1'b1;
            else begin
              load_err <= 1'b1;
              err_code <= 2'd2;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bdd_tree_loader.sv
// Table-driven frame tests plus hand sequences for timeout/abort/reset; memory writes
// are checked against a scoreboard queue filled while the frame bytes are driven.
module tb_bdd_tree_loader;

  logic        clk, rst_n;
  logic [7:0]  s_data;
  logic        s_valid, s_ready, abort;
  logic        coef_we, child_we;
  logic [5:0]  coef_addr, child_addr;
  logic [47:0] coef_wdata;
  logic [17:0] child_wdata;
  logic        load_busy, tree_valid, load_err;
  logic [1:0]  err_code;

  bdd_tree_loader #(.ADDR_WIDTH(6), .TIMEOUT_CYC(1024)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .abort(abort), .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .child_we(child_we), .child_addr(child_addr), .child_wdata(child_wdata),
    .load_busy(load_busy), .tree_valid(tree_valid), .load_err(load_err), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        child;
    logic [5:0]  addr;
    logic [47:0] data;
  } wr_t;

  typedef struct {
    int         n;
    logic [7:0] chk_x;
    logic [1:0] exp_err;
    logic       exp_valid;
  } case_t;

  wr_t   exp_q[$];
  int    total = 0;
  int    bad   = 0;
  int    wr_seen = 0;
  case_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input logic child, input logic [5:0] a, input logic [47:0] d);
    wr_t e;
    total++;
    wr_seen++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_write: got child=%0d addr=%0d data=%0h want none", child, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.child !== child || e.addr !== a || e.data !== d) begin
        bad++;
        $display("FAIL write: got child=%0d addr=%0d data=%0h want child=%0d addr=%0d data=%0h",
                 child, a, d, e.child, e.addr, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (coef_we)  sb_check(1'b0, coef_addr, coef_wdata);
      if (child_we) sb_check(1'b1, child_addr, {30'b0, child_wdata});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  function automatic logic [7:0] pat(input int k, input int j);
    return 8'((k * 29 + j * 13 + 7) & 255);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    s_data  = b;
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // stop < 0: whole frame plus checksum; otherwise only the first 'stop' node bytes.
  task automatic run_frame(input int n, input logic [7:0] chk_x, input int stop);
    logic [7:0]  x, b;
    logic [39:0] c;
    logic [9:0]  ch;
    c  = '0;
    ch = '0;
    send_byte(8'hA5);
    chk("hdr_busy", load_busy, 1);
    chk("hdr_tv", tree_valid, 0);
    send_byte(8'(n));
    x = 8'(n);
    if (n == 0 || n > 64) return;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 9; j++) begin
        if (stop >= 0 && k * 9 + j >= stop) return;
        b = pat(k, j);
        x = x ^ b;
        if (j < 5)  c = {c[31:0], b};
        if (j == 5) exp_q.push_back({1'b0, 6'(k), c, b});
        if (j == 6) ch[9:8] = b[1:0];
        if (j == 7) ch[7:0] = b;
        if (j == 8) exp_q.push_back({1'b1, 6'(k), 30'b0, ch, b});
        send_byte(b);
      end
    end
    send_byte(x ^ chk_x);
  endtask

  task automatic check_idle_clean(input string tag);
    chk({tag, "_busy"}, load_busy, 0);
    chk({tag, "_tv"}, tree_valid, 0);
    chk({tag, "_err"}, {load_err, err_code}, 0);
  endtask

  initial begin
    int w0;
    logic [7:0] spec_bytes [9];

    tbl[0] = '{1,  8'h00, 2'd0, 1'b1};
    tbl[1] = '{0,  8'h00, 2'd1, 1'b0};
    tbl[2] = '{2,  8'h00, 2'd0, 1'b1};
    tbl[3] = '{65, 8'h00, 2'd1, 1'b0};
    tbl[4] = '{3,  8'h00, 2'd0, 1'b1};
    tbl[5] = '{2,  8'h01, 2'd2, 1'b0};
    tbl[6] = '{64, 8'h00, 2'd0, 1'b1};
    tbl[7] = '{5,  8'h00, 2'd0, 1'b1};

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; abort = 1'b0;
    #12;
    chk("rst_ctl", {s_ready, coef_we, child_we, load_busy, tree_valid, load_err, err_code,
                    coef_addr, child_addr}, 0);
    chk("rst_coef", coef_wdata, 0);
    chk("rst_child", child_wdata, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", s_ready, 1);

    // reference single-node vector with literal expectations
    spec_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h80, 8'h01, 8'h02, 8'h03};
    exp_q.push_back({1'b0, 6'd0, 48'h112233445580});
    exp_q.push_back({1'b1, 6'd0, 48'h000000010203});
    send_byte(8'hA5);
    send_byte(8'h01);
    for (int j = 0; j < 9; j++) send_byte(spec_bytes[j]);
    send_byte(8'h90);
    chk("spec1_tv", tree_valid, 1);
    chk("spec1_err", {load_err, err_code}, 0);
    idle(3);
    chk("spec1_q", exp_q.size(), 0);

    for (int i = 0; i < 8; i++) begin
      w0 = wr_seen;
      run_frame(tbl[i].n, tbl[i].chk_x, -1);
      chk($sformatf("tbl%0d_err", i), err_code, tbl[i].exp_err);
      chk($sformatf("tbl%0d_lerr", i), load_err, tbl[i].exp_err != 0);
      chk($sformatf("tbl%0d_tv", i), tree_valid, tbl[i].exp_valid);
      chk($sformatf("tbl%0d_busy", i), load_busy, 0);
      idle(3);
      chk($sformatf("tbl%0d_q", i), exp_q.size(), 0);
      chk($sformatf("tbl%0d_nwr", i), wr_seen - w0,
          (tbl[i].n == 0 || tbl[i].n > 64) ? 0 : 2 * tbl[i].n);
    end

    // timeout: stall after b3 of node0
    run_frame(2, 8'h00, 4);
    idle(1023);
    chk("tmo_pre_err", err_code, 0);
    chk("tmo_pre_busy", load_busy, 1);
    idle(1);
    chk("tmo_err", err_code, 3);
    chk("tmo_lerr", load_err, 1);
    chk("tmo_busy", load_busy, 0);

    // abort in idle clears a held error
    abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
    check_idle_clean("abort_idle");

    // abort after b7; the byte offered with abort would complete node0 if taken
    run_frame(2, 8'h00, 8);
    s_data = 8'hA5; s_valid = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; s_valid = 1'b0;
    check_idle_clean("abort_b7");
    idle(3);
    chk("abort_b7_q", exp_q.size(), 0);

    // abort right after b5: pending coef write must still appear
    w0 = wr_seen;
    run_frame(1, 8'h00, 6);
    abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
    check_idle_clean("abort_b5");
    idle(2);
    chk("abort_b5_nwr", wr_seen - w0, 1);
    chk("abort_b5_q", exp_q.size(), 0);

    run_frame(2, 8'h00, -1);
    chk("post_abort_tv", tree_valid, 1);

    // reset after b2 of node1
    run_frame(2, 8'h00, 12);
    rst_n = 1'b0;
    #1;
    chk("midrst_ctl", {s_ready, coef_we, child_we, load_busy, tree_valid, load_err, err_code}, 0);
    idle(2);
    @(negedge clk) rst_n = 1'b1;
    idle(2);
    chk("midrst_q", exp_q.size(), 0);
    run_frame(3, 8'h00, -1);
    chk("post_rst_tv", tree_valid, 1);
    chk("post_rst_err", err_code, 0);
    idle(3);
    chk("post_rst_q", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
